if_id_buffer: RTL and testbench
===============================

// Module: if_id_buffer
// PURPOSE
//  - Decoupling instruction buffer between the fetch stage and the decode stage.
//  - Holds fetched {instr, pc_plus_4} pairs in a small FIFO so a decode stall does not force
//    fetch to stall in the same cycle.
//  - Drops all held entries when decode resolves a taken branch or jump.
//  - ready_f is the fetch stage's enable (its not-stall input).
// PARAMETERS
//  DATA_W  32  width of the instruction field and of the pc_plus_4 field
//  DEPTH   2   number of entries; power of two, >= 2
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  instr_f      in   DATA_W  instruction from fetch
//  pc_plus_4_f  in   DATA_W  PC+4 from fetch
//  valid_f      in   1       fetch offers an entry this cycle
//  ready_f      out  1       buffer accepts an entry; drives the fetch enable
//  stall_d      in   1       hazard unit holds decode; head entry is not consumed
//  flush_d      in   1       taken branch/jump/jr in decode; discard all contents
//  instr_d      out  DATA_W  head instruction to decode
//  pc_plus_4_d  out  DATA_W  head PC+4 to decode
//  valid_d      out  1       head entry is valid
// BEHAVIOUR
//  - Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, count=0, valid_d=0, instr_d=0, pc_plus_4_d=0,
//    ready_f=1. Applies immediately, including mid-stream; all contents are lost.
//  - count width is $clog2(DEPTH)+1.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH with no special case.
//  - push = valid_f & ready_f & ~flush_d. pop = valid_d & ~stall_d & ~flush_d.
//  - ready_f = (count != DEPTH). Combinational from count only.
//    - There is no pass-through when full, so a push is never accepted while full, even if a
//      pop occurs in the same cycle.
//  - push: store at wr_ptr, wr_ptr+1. pop: rd_ptr+1.
//  - push & pop: count unchanged. push only: count+1. pop only: count-1.
//  - Outputs:
//    - valid_d = (count != 0).
//    - instr_d and pc_plus_4_d are the entry at rd_ptr when valid_d.
//    - When empty, both are forced to 0. Instruction 0 is sll $0,$0,0, i.e. a NOP.
//  - Latency: an entry pushed in cycle N appears on instr_d in cycle N+1 (one cycle).
//  - flush_d=1: next cycle count=0, rd_ptr=wr_ptr=0, valid_d=0.
//    - Any push in the same cycle is discarded.
//    - flush_d has priority over stall_d.
//    - ready_f is unaffected during the flush cycle.
//  - stall_d=1 with count=DEPTH: ready_f=0, and fetch holds the PC. Contents are frozen.
//  - Empty with stall_d=1: push still accepted, and valid_d rises next cycle.
//  - Storage entries are not reset; only pointers, count and outputs are reset.
// CONFIGURATION
//  - Macro IF_ID_BYPASS_EN.
//  - Defined:
//    - When count==0 and valid_f=1, instr_f and pc_plus_4_f drive instr_d and pc_plus_4_d
//      combinationally, and valid_d=1 in the same cycle.
//    - If decode also consumes it (~stall_d & ~flush_d), the entry is not written and count
//      stays 0.
//    - If stall_d=1, the entry is written as normal.
//    - Latency is 0 cycles when empty.
//  - Undefined: no combinational path from the *_f inputs to the *_d outputs; latency is
//    always 1 cycle.
// STRUCTURE
//  - Package mips_pkg: localparam NOP_INSTR = 32'h0000_0000, WORD_W = 32.
//  - Shared with the fetch and decode stages.
//  - One sub-module: wrap_ptr (parameter W; inputs clk, rst_n, inc, clr; output ptr).
//    Instanced twice, for wr_ptr and rd_ptr.
//  - The storage array, count and output mux are inline.
// TESTING
//  1 Reset with rst_n=0 mid-stream while count=2 -> next edge: valid_d=0, instr_d=0, ready_f=1.
//  2 Push 0x8C080004 / 0x00400024, stall_d=0 -> next cycle: instr_d=0x8C080004,
//    pc_plus_4_d=0x00400024, valid_d=1. With BYPASS: the same values appear in the same cycle.
//  3 stall_d=1, push 3 entries -> count=2, ready_f=0 after the 2nd push.
//    The 3rd entry is not accepted. Head stays entry 1.
//  4 Full, then stall_d drops -> entry 1 is popped. ready_f=1 the following cycle.
//    Entries leave in order 1, 2.
//  5 count=2 with flush_d=1 and valid_f=1 -> next cycle: valid_d=0, count=0.
//    The offered entry is dropped.
//  6 Stream of 8 pushes with pops interleaved -> pointers wrap.
//    Output order matches input order with no loss or duplication.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants used by the fetch, IF/ID and decode stages.
package mips_pkg;
  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0
endpackage

// File: rtl/if_id_buffer_wrap_ptr.sv
// Modulo-2^W pointer with a synchronous clear and an increment.
// The clear wins over the increment.
module wrap_ptr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= '0;
    end else if (clr) begin
      ptr_reg <= '0;
    end else if (inc) begin
      ptr_reg <= ptr_reg + W'(1);
    end
  end

  assign ptr = ptr_reg;
endmodule

// File: rtl/if_id_buffer.sv
// IF/ID decoupling FIFO between fetch and decode; flush drops all held entries.
// Optional macro IF_ID_BYPASS_EN adds a zero-latency path from fetch to decode when empty.
module if_id_buffer
  import mips_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr_f,
  input  logic [DATA_W-1:0] pc_plus_4_f,
  input  logic              valid_f,
  output logic              ready_f,
  input  logic              stall_d,
  input  logic              flush_d,
  output logic [DATA_W-1:0] instr_d,
  output logic [DATA_W-1:0] pc_plus_4_d,
  output logic              valid_d
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic [DATA_W-1:0] instr_rd [DEPTH];
  logic [DATA_W-1:0] pc_rd    [DEPTH];
  logic              empty;
  logic              bypass;
  logic              bypass_take;
  logic              push;
  logic              pop;

  assign empty   = (count_reg == '0);
  assign ready_f = (count_reg != CNT_W'(DEPTH));

`ifdef IF_ID_BYPASS_EN
  // An entry offered while empty is shown to decode at once; it is only stored if decode holds.
  assign bypass      = empty & valid_f;
  assign bypass_take = bypass & ~stall_d & ~flush_d;
`else
  assign bypass      = 1'b0;
  assign bypass_take = 1'b0;
`endif

  assign push = valid_f & ready_f & ~flush_d & ~bypass_take;
  assign pop  = ~empty & ~stall_d & ~flush_d;

  wrap_ptr #(.W(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (push),
    .clr   (flush_d),
    .ptr   (wr_ptr)
  );

  wrap_ptr #(.W(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (pop),
    .clr   (flush_d),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately left unreset; valid_d masks stale contents.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [DATA_W-1:0] instr_reg;
      logic [DATA_W-1:0] pc_reg;

      always_ff @(posedge clk) begin
        if (push && (wr_ptr == PTR_W'(gi))) begin
          instr_reg <= instr_f;
          pc_reg    <= pc_plus_4_f;
        end
      end

      assign instr_rd[gi] = instr_reg;
      assign pc_rd[gi]    = pc_reg;
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (flush_d) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_reg + CNT_W'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  always_comb begin
    valid_d     = ~empty | bypass;
    instr_d     = DATA_W'(NOP_INSTR);
    pc_plus_4_d = '0;
    if (!empty) begin
      instr_d     = instr_rd[rd_ptr];
      pc_plus_4_d = pc_rd[rd_ptr];
    end else if (bypass) begin
      instr_d     = instr_f;
      pc_plus_4_d = pc_plus_4_f;
    end
  end
endmodule

// File: tb/tb_if_id_buffer.sv
// Directed self-checking bench for if_id_buffer (DEPTH=2); queue model for the streaming step.
module tb_if_id_buffer;
  logic        clk;
  logic        rst_n;
  logic [31:0] instr_f;
  logic [31:0] pc_plus_4_f;
  logic        valid_f;
  logic        ready_f;
  logic        stall_d;
  logic        flush_d;
  logic [31:0] instr_d;
  logic [31:0] pc_plus_4_d;
  logic        valid_d;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  if_id_buffer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_f     (instr_f),
    .pc_plus_4_f (pc_plus_4_f),
    .valid_f     (valid_f),
    .ready_f     (ready_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .instr_d     (instr_d),
    .pc_plus_4_d (pc_plus_4_d),
    .valid_d     (valid_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                       input logic s, input logic f);
    valid_f     = v;
    instr_f     = i;
    pc_plus_4_f = p;
    stall_d     = s;
    flush_d     = f;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] q_i [$];
  logic [31:0] q_p [$];
  logic [15:0] vf_pat;
  logic [15:0] st_pat;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    $display("reset: valid_d=%0b instr_d=%h ready_f=%0b", valid_d, instr_d, ready_f);
    chk("reset_valid", {31'b0, valid_d}, 32'd0);
    chk("reset_instr", instr_d, 32'h0);
    chk("reset_pc", pc_plus_4_d, 32'h0);
    chk("reset_ready", {31'b0, ready_f}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Single push, one-cycle latency (zero with bypass)
    drive(1'b1, 32'h8C08_0004, 32'h0040_0024, 1'b0, 1'b0);
`ifdef IF_ID_BYPASS_EN
    #1;
    chk("bypass_instr", instr_d, 32'h8C08_0004);
    chk("bypass_valid", {31'b0, valid_d}, 32'd1);
`endif
    tick();
    $display("push1: instr_d=%h pc=%h valid_d=%0b", instr_d, pc_plus_4_d, valid_d);
    chk("push_instr", instr_d, 32'h8C08_0004);
    chk("push_pc", pc_plus_4_d, 32'h0040_0024);
    chk("push_valid", {31'b0, valid_d}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    $display("pop1: valid_d=%0b instr_d=%h", valid_d, instr_d);
    chk("pop_empty_valid", {31'b0, valid_d}, 32'd0);
    chk("pop_empty_nop", instr_d, 32'h0);

    // Fill under stall; third offer refused
    drive(1'b1, 32'h1111_1111, 32'h0000_1004, 1'b1, 1'b0);
    tick();
    $display("stall push A1: instr_d=%h ready_f=%0b", instr_d, ready_f);
    chk("stall_push1_instr", instr_d, 32'h1111_1111);
    chk("stall_push1_ready", {31'b0, ready_f}, 32'd1);
    drive(1'b1, 32'h2222_2222, 32'h0000_1008, 1'b1, 1'b0);
    tick();
    $display("stall push A2: instr_d=%h ready_f=%0b", instr_d, ready_f);
    chk("full_ready", {31'b0, ready_f}, 32'd0);
    chk("full_head", instr_d, 32'h1111_1111);
    drive(1'b1, 32'h3333_3333, 32'h0000_100C, 1'b1, 1'b0);
    tick();
    $display("stall push A3: instr_d=%h ready_f=%0b", instr_d, ready_f);
    chk("full_hold_ready", {31'b0, ready_f}, 32'd0);
    chk("full_hold_head", instr_d, 32'h1111_1111);
    chk("full_hold_pc", pc_plus_4_d, 32'h0000_1004);

    // Release stall: drain in order
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    $display("drain1: instr_d=%h ready_f=%0b", instr_d, ready_f);
    chk("drain_head2", instr_d, 32'h2222_2222);
    chk("drain_pc2", pc_plus_4_d, 32'h0000_1008);
    chk("drain_ready", {31'b0, ready_f}, 32'd1);
    tick();
    $display("drain2: valid_d=%0b", valid_d);
    chk("drain_third_dropped", {31'b0, valid_d}, 32'd0);

    // Flush while full with a fetch offer
    drive(1'b1, 32'hB000_0001, 32'h0000_2004, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hB000_0002, 32'h0000_2008, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hB000_0003, 32'h0000_200C, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    $display("flush full: valid_d=%0b ready_f=%0b", valid_d, ready_f);
    chk("flush_full_valid", {31'b0, valid_d}, 32'd0);
    chk("flush_full_ready", {31'b0, ready_f}, 32'd1);
    tick();
    chk("flush_full_dropped", {31'b0, valid_d}, 32'd0);

    // Flush with one held entry discards the same-cycle push
    drive(1'b1, 32'hC000_0001, 32'h0000_3004, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hC000_0002, 32'h0000_3008, 1'b1, 1'b1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    $display("flush one: valid_d=%0b", valid_d);
    chk("flush_push_dropped", {31'b0, valid_d}, 32'd0);
    drive(1'b1, 32'hD000_0001, 32'h0000_4004, 1'b1, 1'b0);
    tick();
    $display("post-flush push: instr_d=%h", instr_d);
    chk("post_flush_head", instr_d, 32'hD000_0001);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("post_flush_drained", {31'b0, valid_d}, 32'd0);

    // Streaming: 8 pushes with interleaved stalls, compared against a queue model
    vf_pat = 16'b0101_1101_1011_0111;
    st_pat = 16'b0000_1000_0110_0110;
    begin
      int pushed = 0;
      for (int c = 0; c < 16; c++) begin
        logic v;
        logic m_push;
        logic m_pop;
        v = vf_pat[c] && (pushed < 8);
        drive(v, 32'hE000_0000 + 32'(pushed), 32'h0000_5000 + 32'(4 * pushed), st_pat[c], 1'b0);
        m_push = v && (q_i.size() != 2);
        m_pop  = (q_i.size() != 0) && !st_pat[c];
        if (m_pop) begin
          void'(q_i.pop_front());
          void'(q_p.pop_front());
        end
        if (m_push) begin
          q_i.push_back(instr_f);
          q_p.push_back(pc_plus_4_f);
          pushed++;
        end
        tick();
        $display("stream c=%0d: valid_d=%0b instr_d=%h pc=%h ready_f=%0b", c, valid_d, instr_d, pc_plus_4_d, ready_f);
        chk("stream_valid", {31'b0, valid_d}, {31'b0, q_i.size() != 0});
        chk("stream_ready", {31'b0, ready_f}, {31'b0, q_i.size() != 2});
        if (q_i.size() != 0) begin
          chk("stream_instr", instr_d, q_i[0]);
          chk("stream_pc", pc_plus_4_d, q_p[0]);
        end
      end
      chk("stream_pushed", 32'(pushed), 32'd8);
    end

    // Asynchronous reset while full
    drive(1'b1, 32'hF000_0001, 32'h0000_6004, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'hF000_0002, 32'h0000_6008, 1'b1, 1'b0);
    tick();
    chk("pre_reset_full", {31'b0, ready_f}, 32'd0);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    $display("async reset: valid_d=%0b instr_d=%h ready_f=%0b", valid_d, instr_d, ready_f);
    chk("async_reset_valid", {31'b0, valid_d}, 32'd0);
    chk("async_reset_instr", instr_d, 32'h0);
    chk("async_reset_ready", {31'b0, ready_f}, 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("after_reset_empty", {31'b0, valid_d}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
